// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a sign-fix cycle and a one-cycle done pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   addend_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   wb_data_q;

    // Accept-time decode
    logic            is_div_d, a_signed_d, b_signed_d, a_neg_d, b_neg_d, neg_d;
    logic [XLEN-1:0] abs_a_d, abs_b_d;
    logic            div_zero_d, div_ovf_d;
    logic [XLEN-1:0] special_res_d;

    always_comb begin
        is_div_d   = funct3[2];
        a_signed_d = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed_d = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg_d    = a_signed_d & op_a[XLEN-1];
        b_neg_d    = b_signed_d & op_b[XLEN-1];
        abs_a_d    = a_neg_d ? (~op_a + 1'b1) : op_a;
        abs_b_d    = b_neg_d ? (~op_b + 1'b1) : op_b;
        // Remainder follows the dividend's sign; everything else follows the sign xor.
        neg_d      = (is_div_d && funct3[1]) ? a_neg_d : (a_neg_d ^ b_neg_d);
        div_zero_d = is_div_d && (op_b == '0);
        div_ovf_d  = is_div_d && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (op_b == '1);
        special_res_d = '0;
        if (div_zero_d)
            special_res_d = funct3[1] ? op_a : '1;
        else if (div_ovf_d)
            special_res_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration of each algorithm; div packs {remainder, quotient} into prod_q
    logic [XLEN:0]     mul_sum_d;
    logic [2*XLEN-1:0] mul_next_d;
    logic [XLEN:0]     div_shift_d, div_diff_d;
    logic [2*XLEN-1:0] div_next_d;

    always_comb begin
        mul_sum_d   = {1'b0, prod_q[2*XLEN-1:XLEN]}
                      + (prod_q[0] ? {1'b0, addend_q} : {(XLEN+1){1'b0}});
        mul_next_d  = {mul_sum_d, prod_q[XLEN-1:1]};
        div_shift_d = prod_q[2*XLEN-1:XLEN-1];
        div_diff_d  = div_shift_d - {1'b0, addend_q};
        div_next_d  = div_diff_d[XLEN]
                      ? {div_shift_d[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                      : {div_diff_d[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_signed_d;
    logic [XLEN-1:0]   div_sel_d, fix_res_d;

    always_comb begin
        prod_signed_d = neg_q ? (~prod_q + 1'b1) : prod_q;
        div_sel_d     = f3_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        if (f3_q[2])
            fix_res_d = neg_q ? (~div_sel_d + 1'b1) : div_sel_d;
        else if (f3_q[1:0] == 2'b00)
            fix_res_d = prod_signed_d[XLEN-1:0];
        else
            fix_res_d = prod_signed_d[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            f3_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            addend_q  <= '0;
            prod_q    <= '0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        f3_q  <= funct3;
                        rd_q  <= rd;
                        neg_q <= neg_d;
                        cnt_q <= '0;
                        if (div_zero_d || div_ovf_d) begin
                            wb_data_q <= special_res_d;
                            state_q   <= S_DONE;
                        end else begin
                            addend_q <= is_div_d ? abs_b_d : abs_a_d;
                            prod_q   <= {{XLEN{1'b0}}, is_div_d ? abs_a_d : abs_b_d};
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        prod_q <= f3_q[2] ? div_next_d : mul_next_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(XLEN - 1))
                            state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        wb_data_q <= fix_res_d;
                        state_q   <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A flush landing on the done cycle suppresses the pulse and the write
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE) && !flush;
    assign wb_we   = done && (rd_q != 5'd0);
    assign wb_addr = rd_q;
    assign wb_data = wb_data_q;

endmodule
